// File: rtl/waveform_reader.sv
// Streams one frame of DEPTH samples from a synchronous-read RAM to a ready/valid consumer,
// one beat at a time, and publishes the unsigned min/max of each completed frame.
module waveform_reader #(
  parameter int DEPTH  = 200,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_start,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [DATA_W-1:0] wave_min,
  output logic [DATA_W-1:0] wave_max,
  output logic              stats_valid
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CAPTURE, S_SEND, S_DONE} state_t;

  state_t              r_state, w_next;
  logic                r_sync1, r_sync2, r_sync3;
  logic [ADDR_W-1:0]   r_index;
  logic [DATA_W-1:0]   r_acc_min, r_acc_max;
  logic                w_start, w_xfer, w_at_last;

  // read_start crosses in from another domain; the third flop turns it into a rising-edge pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= read_start;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_start   = r_sync2 & ~r_sync3;
  assign w_at_last = (r_index == LAST_IDX);
  assign w_xfer    = (r_state == S_SEND) & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    ram_rd_en   = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    busy        = 1'b1;
    stats_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_start) w_next = S_FETCH;
      end
      S_FETCH: begin
        ram_rd_en = 1'b1;
        w_next    = S_CAPTURE;
      end
      S_CAPTURE: w_next = S_SEND;
      S_SEND: begin
        out_valid = 1'b1;
        out_last  = w_at_last;
        if (w_xfer) w_next = w_at_last ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        stats_valid = 1'b1;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign ram_rd_addr = r_index;

  // Sample 0 seeds both accumulators so stale values from an earlier frame never leak in
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_index   <= '0;
      out_data  <= '0;
      r_acc_min <= '0;
      r_acc_max <= '0;
      wave_min  <= '0;
      wave_max  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) r_index <= '0;
        S_CAPTURE: begin
          out_data <= ram_rd_data;
          if (r_index == '0) begin
            r_acc_min <= ram_rd_data;
            r_acc_max <= ram_rd_data;
          end else begin
            if (ram_rd_data < r_acc_min) r_acc_min <= ram_rd_data;
            if (ram_rd_data > r_acc_max) r_acc_max <= ram_rd_data;
          end
        end
        S_SEND: if (w_xfer && !w_at_last) r_index <= r_index + ADDR_W'(1);
        S_DONE: begin
          wave_min <= r_acc_min;
          wave_max <= r_acc_max;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_waveform_reader.sv
// Directed-plus-random bench for waveform_reader: a RAM model feeds the reader, a monitor logs
// every accepted beat, and each frame is compared against the expected RAM contents and min/max.
module tb_waveform_reader;

  localparam int DEPTH  = 200;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int LOG_N  = 4096;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              read_start = 1'b0;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_last;
  logic              busy;
  logic [DATA_W-1:0] wave_min;
  logic [DATA_W-1:0] wave_max;
  logic              stats_valid;

  waveform_reader #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .read_start(read_start),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .wave_min(wave_min), .wave_max(wave_max), .stats_valid(stats_valid)
  );

  always #5 clk = ~clk;

  // synchronous-read RAM: data appears the cycle after the read strobe
  logic [DATA_W-1:0] mem [256];
  logic [DATA_W-1:0] ram_q = '0;
  always @(posedge clk) if (ram_rd_en) ram_q <= mem[ram_rd_addr];
  assign ram_rd_data = ram_q;

  logic rand_ready = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // monitor: log accepted beats and tally protocol violations
  logic [DATA_W-1:0] beat_data [LOG_N];
  logic              beat_last [LOG_N];
  int beat_cnt = 0, stats_cnt = 0, busy_cyc = 0, viol = 0;
  logic prev_stall = 1'b0, prev_stats = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      prev_stats = 1'b0;
    end else begin
      if (busy) busy_cyc++;
      if (stats_valid) stats_cnt++;
      if (stats_valid && prev_stats) viol++;
      if (prev_stall && (!out_valid || out_data !== prev_data)) viol++;
      if (ram_rd_en && (out_valid || int'(ram_rd_addr) >= DEPTH)) viol++;
      if (out_last && !out_valid) viol++;
      if (out_valid && out_ready) begin
        if (beat_cnt < LOG_N) begin
          beat_data[beat_cnt] = out_data;
          beat_last[beat_cnt] = out_last;
        end
        beat_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_stats = stats_valid;
      prev_data  = out_data;
    end
  end

  int n_pass = 0, n_total = 0;
  int b0, s0, c0, v0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int ref_min();
    int m = 255;
    for (int i = 0; i < DEPTH; i++) if (int'(mem[i]) < m) m = int'(mem[i]);
    return m;
  endfunction

  function automatic int ref_max();
    int m = 0;
    for (int i = 0; i < DEPTH; i++) if (int'(mem[i]) > m) m = int'(mem[i]);
    return m;
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, " ram_rd_en"},   int'(ram_rd_en), 0);
    chk({tag, " ram_rd_addr"}, int'(ram_rd_addr), 0);
    chk({tag, " out_data"},    int'(out_data), 0);
    chk({tag, " out_valid"},   int'(out_valid), 0);
    chk({tag, " out_last"},    int'(out_last), 0);
    chk({tag, " busy"},        int'(busy), 0);
    chk({tag, " wave_min"},    int'(wave_min), 0);
    chk({tag, " wave_max"},    int'(wave_max), 0);
    chk({tag, " stats_valid"}, int'(stats_valid), 0);
  endtask

  // raise read_start for 'hold' cycles from idle and measure the delay to the first RAM read
  task automatic start_frame(input string tag, input int hold);
    int n, lat;
    b0 = beat_cnt; s0 = stats_cnt; c0 = busy_cyc; v0 = viol;
    n = 0; lat = 0;
    read_start = 1'b1;
    while (n < hold || (lat == 0 && n < 8)) begin
      @(negedge clk);
      n++;
      if (n == hold) read_start = 1'b0;
      if (ram_rd_en && lat == 0) lat = n;
    end
    read_start = 1'b0;
    chk({tag, " start latency"}, lat, 3);
  endtask

  task automatic finish_frame(input string tag, input bit check_busy);
    int t, mism, lastbad;
    t = 0;
    while ((busy || stats_cnt == s0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " frame completes"}, int'(t < 5000), 1);
    repeat (20) @(negedge clk);
    mism = 0; lastbad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (b0 + i < LOG_N) begin
        if (beat_data[b0 + i] !== mem[i]) mism++;
        if (beat_last[b0 + i] !== (i == DEPTH - 1)) lastbad++;
      end
    end
    chk({tag, " beat count"},       beat_cnt - b0, DEPTH);
    chk({tag, " data mismatches"},  mism, 0);
    chk({tag, " out_last misplaced"}, lastbad, 0);
    chk({tag, " stats pulses"},     stats_cnt - s0, 1);
    chk({tag, " protocol errors"},  viol - v0, 0);
    chk({tag, " wave_min"},         int'(wave_min), ref_min());
    chk({tag, " wave_max"},         int'(wave_max), ref_max());
    chk({tag, " busy idle after"},  int'(busy), 0);
    if (check_busy) chk({tag, " busy cycles"}, busy_cyc - c0, 3 * DEPTH + 1);
  endtask

  initial begin
    int t;
    @(negedge clk);
    chk_reset_outs("in reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs("idle after reset");

    // ramp: sample value equals its address
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    start_frame("ramp", 2);
    finish_frame("ramp", 1'b1);

    // flat frame with a single low and a single high outlier
    for (int i = 0; i < 256; i++) mem[i] = 8'h80;
    mem[57] = 8'h03; mem[120] = 8'hFE;
    start_frame("outliers", 2);
    finish_frame("outliers", 1'b1);

    // random data under a randomly stalling consumer
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    rand_ready = 1'b1;
    start_frame("stall", 2);
    finish_frame("stall", 1'b0);
    rand_ready = 1'b0;
    repeat (2) @(negedge clk);

    // a second read_start edge mid-frame is ignored
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    start_frame("restart", 2);
    t = 0;
    while (beat_cnt - b0 < 50 && t < 2000) begin @(negedge clk); t++; end
    chk("restart reach beat 50", int'(t < 2000), 1);
    read_start = 1'b1;
    repeat (2) @(negedge clk);
    read_start = 1'b0;
    finish_frame("restart", 1'b1);
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    start_frame("after restart", 2);
    finish_frame("after restart", 1'b1);

    // reset in the middle of a frame
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    start_frame("abort", 2);
    t = 0;
    while (beat_cnt - b0 < 100 && t < 2000) begin @(negedge clk); t++; end
    chk("abort reach beat 100", int'(t < 2000), 1);
    s0 = stats_cnt;
    reset = 1'b1;
    #1;
    chk_reset_outs("mid-frame reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort no stats pulse", stats_cnt - s0, 0);
    chk("abort stays idle", int'(busy), 0);
    start_frame("post abort", 2);
    finish_frame("post abort", 1'b1);

    // long read_start level yields a single frame
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    start_frame("long level", 1000);
    finish_frame("long level", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/waveform_reader.md
WAVEFORM_READER -- requirements
Module: waveform_reader

Interface
REQ-001 Parameter: DEPTH, 200, samples per frame (RAM addresses 0..DEPTH-1).
REQ-002 Parameter: DATA_W, 8, sample width.
REQ-003 Parameter: ADDR_W, 8, RAM address width.
REQ-004 Timing/reset SHALL be fixed: one clock; reset is asynchronous and active-high.
REQ-005 Port SHALL be: clk  in  1  sole clock, rising edge.
REQ-006 Port SHALL be: reset  in  1  asynchronous, active-high.
REQ-007 Port SHALL be: read_start  in  1  frame-ready pulse from the sample writer; asynchronous to clk.
REQ-008 Port SHALL be: ram_rd_en  out  1  RAM read strobe.
REQ-009 Port SHALL be: ram_rd_addr  out  ADDR_W  RAM read address.
REQ-010 Port SHALL be: ram_rd_data  in  DATA_W  RAM data, valid the cycle after ram_rd_en.
REQ-011 Port SHALL be: out_data  out  DATA_W  streamed sample.
REQ-012 Port SHALL be: out_valid  out  1  out_data valid.
REQ-013 Port SHALL be: out_ready  in  1  consumer accepts.
REQ-014 Port SHALL be: out_last  out  1  current beat is sample DEPTH-1.
REQ-015 Port SHALL be: busy  out  1  frame in progress; writer holds off new capture.
REQ-016 Port SHALL be: wave_min  out  DATA_W  minimum of last completed frame.
REQ-017 Port SHALL be: wave_max  out  DATA_W  maximum of last completed frame.
REQ-018 Port SHALL be: stats_valid  out  1  one-cycle pulse when wave_min/wave_max update.

Function
REQ-019 read_start SHALL pass a 2-flop synchronizer plus a third flop; start = sync2 & ~sync3 (rising edge only).
REQ-020 FSM states SHALL be IDLE, FETCH, CAPTURE, SEND, DONE; encoding free.
REQ-021 IDLE -> FETCH on start, with index cleared to 0; start is ignored in any other state.
REQ-022 FETCH: ram_rd_en=1, ram_rd_addr=index; always -> CAPTURE next cycle.
REQ-023 CAPTURE: out_data <= ram_rd_data; min/max accumulators update; -> SEND.
REQ-024 SEND: out_valid=1, out_data stable; beat transfers on out_valid & out_ready.
REQ-025 SEND transitions: on transfer with index==DEPTH-1 -> DONE; on transfer otherwise index+1 -> FETCH; no transfer -> stay.
REQ-026 out_last SHALL be 1 only in SEND with index==DEPTH-1.
REQ-027 DONE: wave_min/wave_max <= accumulators; stats_valid=1 for exactly this cycle; -> IDLE.
REQ-028 Accumulators SHALL load (not compare) on index 0, compare unsigned on all later indices.
REQ-029 wave_min/wave_max SHALL hold between DONE pulses.
REQ-030 busy SHALL be 1 in FETCH, CAPTURE, SEND and DONE, and 0 in IDLE.
REQ-031 Latency: ram_rd_en SHALL first assert in the 3rd clk cycle after the first edge sampling read_start high.
REQ-032 With out_ready held 1, frame duration SHALL be 3*DEPTH+1 cycles of busy.
REQ-033 ram_rd_en SHALL be 0 outside FETCH.
REQ-034 ram_rd_addr SHALL never exceed DEPTH-1; index SHALL never wrap.
REQ-035 out_valid SHALL NOT drop before transfer; out_ready is ignored outside SEND.
REQ-036 read_start held high for many cycles SHALL yield one frame; a new frame needs a low-then-high edge.

Reset
REQ-037 While reset=1, outputs SHALL be:
  - FSM IDLE, index 0, synchronizer flops 0.
  - ram_rd_en=0, ram_rd_addr=0.
  - out_data=0, out_valid=0, out_last=0.
  - busy=0.
  - wave_min=0, wave_max=0, stats_valid=0.
REQ-038 Reset mid-frame SHALL abort immediately; no stats_valid for the aborted frame; the next frame needs a fresh read_start edge.

Verification
REQ-039 The bench SHALL cover these scenarios:
  - RAM 0..199 = addr value, out_ready=1, pulse read_start -> 200 beats 0..199 in order, out_last on beat 199 only, busy high 601 cycles, wave_min=0, wave_max=199, stats_valid single pulse.
  - RAM all 0x80 except addr 57 = 0x03 and addr 120 = 0xFE -> wave_min=0x03, wave_max=0xFE.
  - out_ready toggled randomly (about 50%) -> identical data sequence, out_data stable while out_valid & ~out_ready, no ram_rd_en during stall.
  - Second read_start pulse at beat 50 -> ignored: exactly 200 beats and 1 stats_valid; a later pulse after busy falls starts a new frame.
  - Reset asserted at beat 100 -> all outputs to reset values within the cycle, no stats_valid; wave_min/wave_max = 0; a following read_start gives a full 200-beat frame.
  - read_start held high 1000 cycles -> exactly one frame.
